// File: rtl/shift_rows_pkg.sv
// Shared constants, mode encoding and the per-row rotation helper for the
// AES ShiftRows pipeline.
package shift_rows_pkg;

  localparam int BLOCK_W  = 128;
  localparam int ROW_W    = 32;
  localparam int NUM_ROWS = 4;

  typedef enum logic {
    MODE_FWD = 1'b0,
    MODE_INV = 1'b1
  } mode_e;

  // Rotating a doubled copy turns both directions into one right shift.
  function automatic logic [ROW_W-1:0] rot_row(input logic [ROW_W-1:0] row,
                                               input mode_e mode,
                                               input int unsigned r);
    logic [2*ROW_W-1:0] dbl;
    dbl = {row, row};
    if (mode == MODE_FWD) dbl = dbl >> (ROW_W - 8 * r);
    else                  dbl = dbl >> (8 * r);
    return dbl[ROW_W-1:0];
  endfunction

endpackage

// File: rtl/shift_rows_fifo.sv
// Output buffer: circular store plus a registered head, so the consumer-facing
// outputs never come straight from the array.
module shift_rows_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [W-1:0]               data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [W-1:0]               data_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, rd_next;
  logic [LVL_W-1:0] level_q, level_d;
  logic [W-1:0]     head_q, head_d;
  logic             push, pop;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready_o = !rst_i && (level_q < LVL_W'(DEPTH));
  assign valid_o = (level_q != '0);
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;
  assign data_o  = head_q;
  assign level_o = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = head_q;
    rd_next  = inc_ptr(rd_ptr_q);
    if (push) wr_ptr_d = inc_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = rd_next;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // Head reloads from the incoming beat when it becomes the only entry,
    // otherwise from the stored successor on a pop.
    if (push && ((level_q == '0) || (pop && (level_q == LVL_W'(1)))))
      head_d = data_i;
    else if (pop && (level_q > LVL_W'(1)))
      head_d = mem_q[rd_next];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// Multi-lane AES ShiftRows / InvShiftRows stage with a buffered output.
// Define SHIFT_ROWS_PIPE_STATS_EN to add saturating Stat_Beats/Stat_Stalls.
module shift_rows_pipe
  import shift_rows_pkg::*;
#(
  parameter int LANES = 1,
  parameter int TAG_W = 4,
  parameter int DEPTH = 2
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       In_Valid,
  output logic                       In_Ready,
  input  logic                       In_Mode,
  input  logic [BLOCK_W*LANES-1:0]   In_Data,
  input  logic [TAG_W-1:0]           In_Tag,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic [BLOCK_W*LANES-1:0]   Out_Data,
  output logic [TAG_W-1:0]           Out_Tag,
  output logic                       Out_Mode,
  output logic [$clog2(DEPTH+1)-1:0] Level
`ifdef SHIFT_ROWS_PIPE_STATS_EN
  ,
  output logic [31:0]                Stat_Beats,
  output logic [31:0]                Stat_Stalls
`endif
);

  localparam int DW = BLOCK_W * LANES;
  localparam int FW = DW + TAG_W + 1;

  logic [DW-1:0] xf_data;
  logic [FW-1:0] fifo_out;
  mode_e         in_mode;

  assign in_mode = mode_e'(In_Mode);

  // Lane k row r sits at 32*(4k+r), so one flat index covers every row.
  genvar gi;
  generate
    for (gi = 0; gi < LANES * NUM_ROWS; gi++) begin : g_row
      assign xf_data[gi*ROW_W +: ROW_W] =
        rot_row(In_Data[gi*ROW_W +: ROW_W], in_mode, gi % NUM_ROWS);
    end
  endgenerate

  shift_rows_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .valid_i (In_Valid),
    .ready_o (In_Ready),
    .data_i  ({In_Mode, In_Tag, xf_data}),
    .valid_o (Out_Valid),
    .ready_i (Out_Ready),
    .data_o  (fifo_out),
    .level_o (Level)
  );

  assign Out_Data = fifo_out[DW-1:0];
  assign Out_Tag  = fifo_out[DW +: TAG_W];
  assign Out_Mode = fifo_out[FW-1];

`ifdef SHIFT_ROWS_PIPE_STATS_EN
  logic [31:0] beats_q, beats_d, stalls_q, stalls_d;

  always_comb begin
    beats_d  = beats_q;
    stalls_d = stalls_q;
    if (In_Valid && In_Ready && (beats_q != '1))      beats_d  = beats_q + 1'b1;
    if (Out_Valid && !Out_Ready && (stalls_q != '1)) stalls_d = stalls_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      beats_q  <= beats_d;
      stalls_q <= stalls_d;
    end
  end

  assign Stat_Beats  = beats_q;
  assign Stat_Stalls = stalls_q;
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench for shift_rows_pipe (LANES=4, DEPTH=2): stimulus queues
// expected beats, a negedge monitor pops and compares every handshake.
module tb_shift_rows_pipe;

  localparam int LANES = 4;
  localparam int TAG_W = 4;
  localparam int DEPTH = 2;
  localparam int DW    = 128 * LANES;
  localparam int XW    = DW + TAG_W + 1;

  localparam logic [127:0] V_IN   = 128'hCCDDEEFF_8899AABB_44556677_00112233;
  localparam logic [127:0] V_FWD  = 128'hFFCCDDEE_AABB8899_55667744_00112233;
  localparam logic [127:0] L1_IN  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] L1_FWD = 128'h0C0F0E0D_09080B0A_06050407_03020100;
  localparam logic [127:0] L2_IN  = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;
  localparam logic [127:0] L2_FWD = 128'hEFDEADBE_BABECAFE_23456701_89ABCDEF;
  localparam logic [127:0] L3_IN  = 128'h11223344_55667788_99AABBCC_DDEEFF00;
  localparam logic [127:0] L3_FWD = 128'h44112233_77885566_AABBCC99_DDEEFF00;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             In_Valid, In_Ready, In_Mode;
  logic [DW-1:0]    In_Data;
  logic [TAG_W-1:0] In_Tag;
  logic             Out_Valid, Out_Ready, Out_Mode;
  logic [DW-1:0]    Out_Data;
  logic [TAG_W-1:0] Out_Tag;
  logic [1:0]       Level;
`ifdef SHIFT_ROWS_PIPE_STATS_EN
  logic [31:0]      Stat_Beats, Stat_Stalls;
`endif

  shift_rows_pipe #(.LANES(LANES), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Mode   (In_Mode),
    .In_Data   (In_Data),
    .In_Tag    (In_Tag),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Data  (Out_Data),
    .Out_Tag   (Out_Tag),
    .Out_Mode  (Out_Mode),
    .Level     (Level)
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    ,
    .Stat_Beats  (Stat_Beats),
    .Stat_Stalls (Stat_Stalls)
`endif
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  int cyc   = 0;
  logic [XW-1:0] exp_q[$];

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-level reference: output byte j (MSB-first) of row r takes input byte
  // (j+r)%4 forward, (j-r)%4 inverse.
  function automatic logic [DW-1:0] ref_xf(input logic [DW-1:0] d, input logic m);
    logic [DW-1:0] o;
    o = '0;
    for (int l = 0; l < LANES; l++)
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < 4; j++) begin
          int src;
          src = m ? (j - r + 4) % 4 : (j + r) % 4;
          o[128*l + 32*r + 8*(3-j) +: 8] = d[128*l + 32*r + 8*(3-src) +: 8];
        end
    return o;
  endfunction

  always @(negedge Clk) begin
    if (!Rst && Out_Valid && Out_Ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_unexpected: got %h expected no beat", Out_Data);
      end else begin
        check("out_beat", {Out_Mode, Out_Tag, Out_Data}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_accept();
    int k = 0;
    @(negedge Clk);
    while (!In_Ready && k < 50) begin
      @(negedge Clk);
      k++;
    end
    if (k >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: In_Ready got 0 expected 1");
    end
    tick();
  endtask

  // Leaves In_Valid high so consecutive calls stream back-to-back.
  task automatic send(input logic [DW-1:0] d, input logic m, input logic [TAG_W-1:0] t,
                      input logic [DW-1:0] exp_d, input bit expect_out);
    if (expect_out) exp_q.push_back({m, t, exp_d});
    In_Valid = 1'b1;
    In_Data  = d;
    In_Mode  = m;
    In_Tag   = t;
    wait_accept();
  endtask

  task automatic drain();
    int k = 0;
    Out_Ready = 1'b1;
    while (exp_q.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
    end
    tick();
    Out_Ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] td;
    int c0, out0, max_lvl;
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    logic [31:0] s0;
`endif
    Rst = 1'b1; In_Valid = 1'b0; In_Mode = 1'b0; In_Data = '0; In_Tag = '0; Out_Ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", In_Ready, 0);
    check("rst_out_valid", Out_Valid, 0);
    check("rst_level", Level, 0);
    check("rst_out_data", Out_Data, 0);
    check("rst_out_sideband", {Out_Mode, Out_Tag}, 0);
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    check("rst_stats", {Stat_Beats, Stat_Stalls}, 0);
`endif
    Rst = 1'b0;
    tick();
    check("post_rst_in_ready", In_Ready, 1);

    // Forward vector, single-cycle latency into an empty buffer.
    send({4{V_IN}}, 1'b0, 4'h3, {4{V_FWD}}, 1'b1);
    In_Valid = 1'b0;
    check("lat_out_valid", Out_Valid, 1);
    check("lat_out_data", Out_Data, {4{V_FWD}});
    check("lat_level", Level, 1);
    drain();
    check("empty_out_valid", Out_Valid, 0);
    check("empty_hold_data", Out_Data, {4{V_FWD}});

    // Inverse vector with tag 5.
    Out_Ready = 1'b1;
    send({4{V_FWD}}, 1'b1, 4'h5, {4{V_IN}}, 1'b1);
    In_Valid = 1'b0;
    drain();

    // Distinct content per lane, forward then back again.
    send({L3_IN, L2_IN, L1_IN, V_IN}, 1'b0, 4'hA, {L3_FWD, L2_FWD, L1_FWD, V_FWD}, 1'b1);
    send({L3_FWD, L2_FWD, L1_FWD, V_FWD}, 1'b1, 4'hB, {L3_IN, L2_IN, L1_IN, V_IN}, 1'b1);
    In_Valid = 1'b0;
    drain();

    // Back-pressure: third beat must wait for a pop.
    send({4{L1_IN}}, 1'b0, 4'h1, {4{L1_FWD}}, 1'b1);
    send({4{L2_IN}}, 1'b0, 4'h2, {4{L2_FWD}}, 1'b1);
    In_Data = {4{L3_IN}};
    In_Tag  = 4'h3;
    In_Mode = 1'b0;
    exp_q.push_back({1'b0, 4'h3, {4{L3_FWD}}});
    check("full_in_ready", In_Ready, 0);
    check("full_level", Level, 2);
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    check("stat_beats", Stat_Beats, 6);
    s0 = Stat_Stalls;
`endif
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("bp_level", Level, 2);
      check("bp_in_ready", In_Ready, 0);
      check("bp_stable", {Out_Mode, Out_Tag, Out_Data}, {1'b0, 4'h1, {4{L1_FWD}}});
`ifdef SHIFT_ROWS_PIPE_STATS_EN
      check("bp_stalls", Stat_Stalls, s0 + 32'(i));
`endif
    end
    Out_Ready = 1'b1;
    wait_accept();
    In_Valid = 1'b0;
    drain();

    // Full throughput, alternating modes.
    Out_Ready = 1'b1;
    max_lvl = 0;
    out0 = n_out;
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      for (int w = 0; w < 16; w++) td[32*w +: 32] = 32'h9E3779B9 * 32'(i * 16 + w + 1);
      send(td, i[0], i[3:0], ref_xf(td, i[0]), 1'b1);
      if (int'(Level) > max_lvl) max_lvl = int'(Level);
    end
    check("tput_cycles", cyc - c0, 100);
    In_Valid = 1'b0;
    drain();
    check("tput_beats_out", n_out - out0, 100);
    check("tput_max_level", max_lvl, 1);

    // Reset with two beats buffered: they must vanish.
    send({4{L2_IN}}, 1'b0, 4'h6, '0, 1'b0);
    send({4{L3_IN}}, 1'b1, 4'h7, '0, 1'b0);
    In_Valid = 1'b0;
    check("pre_rst_level", Level, 2);
    Rst = 1'b1;
    #1;
    check("rst_hold_in_ready", In_Ready, 0);
    tick();
    Rst = 1'b0;
    check("mid_rst_out_valid", Out_Valid, 0);
    check("mid_rst_level", Level, 0);
    check("mid_rst_out_data", Out_Data, 0);
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    check("mid_rst_stats", Stat_Beats, 0);
`endif
    Out_Ready = 1'b1;
    repeat (3) tick();
    send({4{V_IN}}, 1'b0, 4'h9, {4{V_FWD}}, 1'b1);
    In_Valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_rows_pipe.md
SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 Parameter LANES, default 1 (legal 1..4): number of 128-bit AES states carried per beat.
REQ-002 Parameter TAG_W, default 4 (legal 1..16): width of the sideband tag carried with each beat.
REQ-003 Parameter DEPTH, default 2 (legal 2, 4, 8): number of entries in the output buffer.
REQ-004 Clk  in  1  single clock; all logic rising-edge.
REQ-005 Rst  in  1  reset, synchronous, active-high.
REQ-006 In_Valid  in  1  producer beat valid.
REQ-007 In_Ready  out  1  block can accept a beat.
REQ-008 In_Mode  in  1  0 = forward ShiftRows, 1 = inverse ShiftRows.
REQ-009 In_Data  in  128*LANES  states; lane k occupies [128k+127:128k].
REQ-010 In_Tag  in  TAG_W  opaque sideband, returned unchanged.
REQ-011 Out_Valid  out  1  output beat valid.
REQ-012 Out_Ready  in  1  consumer accepts the beat.
REQ-013 Out_Data  out  128*LANES  transformed states.
REQ-014 Out_Tag / Out_Mode  out  TAG_W / 1  sideband and mode of the output beat.
REQ-015 Level  out  $clog2(DEPTH+1)  number of occupied buffer entries.

Function
REQ-016 Row layout per lane: row r = bits [32r+31:32r], r = 0..3, byte order MSB-first within each row.
REQ-017 Forward mode: row r is rotated left by 8r bits; row 0 passes through unchanged.
REQ-018 Inverse mode: row r is rotated right by 8r bits; the inverse transform is the exact inverse of the forward transform.
REQ-019 The transform is applied per lane, is independent across lanes, and is selected per beat by In_Mode.
REQ-020 Accept = In_Valid && In_Ready; the transformed data, tag and mode are written to the buffer tail on accept.
REQ-021 In_Ready = (Level < DEPTH), with no combinational path from Out_Ready.
REQ-022 Out_Valid = (Level != 0); Out_Data, Out_Tag and Out_Mode are the head entry, driven from registers.
REQ-023 Pop = Out_Valid && Out_Ready; the head advances on pop.
REQ-024 Latency: a beat accepted in cycle N into an empty buffer is presented with Out_Valid in cycle N+1.
REQ-025 Simultaneous push and pop: Level is unchanged and ordering is strict FIFO.
REQ-026 Full: In_Ready is 0, and In_Data is ignored until the cycle after a pop.
REQ-027 Empty: a pop cannot occur; Out_Data holds its last value.
REQ-028 Read and write pointers wrap modulo DEPTH.
REQ-029 While Out_Valid && !Out_Ready, all Out_* signals remain stable.

Reset
REQ-030 While Rst is 1 at a clock edge, the following are cleared: pointers, Level = 0, Out_Valid = 0, Out_Data = 0, Out_Tag = 0, Out_Mode = 0, statistics = 0.
REQ-031 In_Ready is 0 while Rst is asserted and 1 from the first cycle after release.
REQ-032 Reset asserted mid-stream discards all buffered beats, with no partial output.

Configuration
REQ-033 Macro SHIFT_ROWS_PIPE_STATS_EN, when defined, adds the 32-bit outputs Stat_Beats (count of accepts) and Stat_Stalls (count of cycles with Out_Valid && !Out_Ready).
REQ-034 Both statistics counters saturate at 0xFFFFFFFF.
REQ-035 When the macro is undefined, neither the statistics ports nor the counter logic exist.

Structure
REQ-036 The shared package shift_rows_pkg holds BLOCK_W = 128, ROW_W = 32, NUM_ROWS = 4, and the mode enum (MODE_FWD = 0, MODE_INV = 1).
REQ-037 The buffer is the sub-module shift_rows_fifo, parametrised by width and DEPTH; the transform is combinational logic in the top level.

Verification
REQ-038 Forward, LANES = 1: In_Data = 0xCCDDEEFF_8899AABB_44556677_00112233, Mode = 0 -> Out_Data = 0xFFCCDDEE_AABB8899_55667744_00112233 in the next cycle.
REQ-039 Inverse: input 0xFFCCDDEE_AABB8899_55667744_00112233, Mode = 1 -> output 0xCCDDEEFF_8899AABB_44556677_00112233, and tag 0x5 is returned as 0x5.
REQ-040 Back-pressure, DEPTH = 2: with Out_Ready held at 0, push 3 beats -> In_Ready = 0 after 2 accepts, Level = 2, outputs stable, and with stats enabled Stat_Stalls increments every cycle.
REQ-041 Full throughput: Out_Ready = 1 and In_Valid = 1 for 100 cycles with alternating modes -> 100 beats out, in order, each correctly transformed, Level <= 1.
REQ-042 LANES = 4: each lane carries distinct data with mixed content -> every lane is transformed independently and matches the reference model.
REQ-043 Reset mid-stream: Level = 2, assert Rst for 1 cycle -> Out_Valid = 0, Level = 0, Out_Data = 0, and the old beats never appear on the output.
